// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared widths, result word layout and scheduler state encoding
package miner_pkg;

  localparam int NONCE_W  = 32;
  localparam int HASH_W   = 256;
  localparam int RESULT_W = NONCE_W + HASH_W;

  typedef struct packed {
    logic [NONCE_W-1:0] nonce;
    logic [HASH_W-1:0]  hash;
  } result_t;

  // All-ones nonce with an all-zero hash tells the host the job had no solution.
  localparam result_t NO_SOLUTION = '{nonce: 32'hFFFF_FFFF, hash: '0};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter; first request at or above ptr wins, with wrap
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          w_hit;
  logic [IW-1:0] w_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_hit     = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = IW'((int'(ptr) + i) % N);
      if (!w_hit && req[w_idx]) begin
        w_hit        = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - splits the nonce space into chunks, feeds the hashing cores and reports one result
module nonce_scheduler #(
  parameter int CORES     = 1,
  parameter int CHUNK_LOG = 24,
  parameter int NONCE_W   = miner_pkg::NONCE_W,
  parameter int HASH_W    = miner_pkg::HASH_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        job_valid,
  output logic                        job_ready,
  output logic [CORES-1:0]            core_start,
  output logic [NONCE_W-1:0]          core_base,
  output logic                        core_abort,
  input  logic [CORES-1:0]            core_done,
  input  logic [CORES-1:0]            core_found,
  input  logic [CORES*NONCE_W-1:0]    core_nonce,
  input  logic [CORES*HASH_W-1:0]     core_hash,
  input  logic                        tx_busy,
  output logic                        send_data,
  output logic [NONCE_W+HASH_W-1:0]   tx_data,
  output logic [1:0]                  state_o
);

  import miner_pkg::*;

  localparam int IW = (CORES > 1) ? $clog2(CORES) : 1;
  localparam logic [NONCE_W:0] CHUNK_INC = {{NONCE_W{1'b0}}, 1'b1} << CHUNK_LOG;

  sched_state_e        r_state, w_state_nxt;
  logic [NONCE_W-1:0]  r_next_base, w_next_base_nxt;
  logic                r_exhausted, w_exhausted_nxt;
  logic [CORES-1:0]    r_busy, w_busy_nxt;
  logic [IW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [CORES-1:0]    r_core_start, w_core_start_nxt;
  logic [NONCE_W-1:0]  r_core_base, w_core_base_nxt;
  logic                r_core_abort, w_core_abort_nxt;
  logic                r_send_data, w_send_data_nxt;
  result_t             r_tx_data, w_tx_data_nxt;

  logic                w_found;
  logic [CORES-1:0]    w_grant;
  logic [IW-1:0]       w_win_idx;
  logic [IW-1:0]       w_rr_inc;
  result_t             w_win_result;
  logic                w_free_hit;
  logic [CORES-1:0]    w_free_onehot;
  logic [NONCE_W:0]    w_sum;

  rr_arbiter #(.N(CORES)) u_arb (
    .req       (core_found),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_win_idx)
  );

  assign w_found            = |core_found;
  assign w_win_result.nonce = core_nonce[int'(w_win_idx)*NONCE_W +: NONCE_W];
  assign w_win_result.hash  = core_hash[int'(w_win_idx)*HASH_W +: HASH_W];
  assign w_rr_inc           = (int'(w_win_idx) == CORES - 1) ? '0 : w_win_idx + 1'b1;
  // The carry out of the widened add marks the last chunk of the nonce space.
  assign w_sum              = {1'b0, r_next_base} + CHUNK_INC;

  always_comb begin
    w_free_hit    = 1'b0;
    w_free_onehot = '0;
    for (int i = 0; i < CORES; i++) begin
      if (!w_free_hit && !r_busy[i]) begin
        w_free_hit       = 1'b1;
        w_free_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (job_valid) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_found)                          w_state_nxt = ST_REPORT;
        else if (r_exhausted && r_busy == '0) w_state_nxt = ST_REPORT;
      end
      ST_REPORT: if (!tx_busy) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_next_base_nxt  = r_next_base;
    w_exhausted_nxt  = r_exhausted;
    w_busy_nxt       = r_busy;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_core_start_nxt = '0;
    w_core_base_nxt  = r_core_base;
    w_core_abort_nxt = 1'b0;
    w_send_data_nxt  = 1'b0;
    w_tx_data_nxt    = r_tx_data;
    case (r_state)
      ST_IDLE: begin
        if (job_valid) begin
          w_next_base_nxt = '0;
          w_exhausted_nxt = 1'b0;
          w_busy_nxt      = '0;
        end
      end
      ST_RUN: begin
        if (w_found) begin
          w_tx_data_nxt    = w_win_result;
          w_core_abort_nxt = 1'b1;
          w_busy_nxt       = '0;
          w_rr_ptr_nxt     = w_rr_inc;
        end else if (r_exhausted && r_busy == '0) begin
          w_tx_data_nxt = NO_SOLUTION;
        end else begin
          // Dispatch looks at the busy mask before this cycle's done pulses.
          w_busy_nxt = r_busy & ~core_done;
          if (!r_exhausted && w_free_hit) begin
            w_core_start_nxt = w_free_onehot;
            w_core_base_nxt  = r_next_base;
            w_busy_nxt       = w_busy_nxt | w_free_onehot;
            w_next_base_nxt  = w_sum[NONCE_W-1:0];
            w_exhausted_nxt  = w_sum[NONCE_W];
          end
        end
      end
      ST_REPORT: begin
        if (!tx_busy) w_send_data_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_next_base  <= '0;
      r_exhausted  <= 1'b0;
      r_busy       <= '0;
      r_rr_ptr     <= '0;
      r_core_start <= '0;
      r_core_base  <= '0;
      r_core_abort <= 1'b0;
      r_send_data  <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_next_base  <= w_next_base_nxt;
      r_exhausted  <= w_exhausted_nxt;
      r_busy       <= w_busy_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_core_start <= w_core_start_nxt;
      r_core_base  <= w_core_base_nxt;
      r_core_abort <= w_core_abort_nxt;
      r_send_data  <= w_send_data_nxt;
      r_tx_data    <= w_tx_data_nxt;
    end
  end

  assign job_ready  = (r_state == ST_IDLE);
  assign core_start = r_core_start;
  assign core_base  = r_core_base;
  assign core_abort = r_core_abort;
  assign send_data  = r_send_data;
  assign tx_data    = r_tx_data;
  assign state_o    = r_state;

endmodule

// File: tb/tb_nonce_scheduler.sv
// tb/tb_nonce_scheduler.sv - directed bench: two cores with 16-nonce chunks, and one core with 2^31 chunks
module tb_nonce_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_job_valid, a_job_ready, a_core_abort, a_tx_busy, a_send_data;
  logic [1:0]    a_core_start, a_core_done, a_core_found, a_state;
  logic [31:0]   a_core_base;
  logic [63:0]   a_core_nonce;
  logic [511:0]  a_core_hash;
  logic [287:0]  a_tx_data;

  logic          b_rst, b_job_valid, b_job_ready, b_core_abort, b_tx_busy, b_send_data;
  logic [0:0]    b_core_start, b_core_done, b_core_found;
  logic [1:0]    b_state;
  logic [31:0]   b_core_base, b_core_nonce;
  logic [255:0]  b_core_hash;
  logic [287:0]  b_tx_data;

  nonce_scheduler #(.CORES(2), .CHUNK_LOG(4)) dut_a (
    .clk(clk), .rst(a_rst), .job_valid(a_job_valid), .job_ready(a_job_ready),
    .core_start(a_core_start), .core_base(a_core_base), .core_abort(a_core_abort),
    .core_done(a_core_done), .core_found(a_core_found), .core_nonce(a_core_nonce),
    .core_hash(a_core_hash), .tx_busy(a_tx_busy), .send_data(a_send_data),
    .tx_data(a_tx_data), .state_o(a_state)
  );

  nonce_scheduler #(.CORES(1), .CHUNK_LOG(31)) dut_b (
    .clk(clk), .rst(b_rst), .job_valid(b_job_valid), .job_ready(b_job_ready),
    .core_start(b_core_start), .core_base(b_core_base), .core_abort(b_core_abort),
    .core_done(b_core_done), .core_found(b_core_found), .core_nonce(b_core_nonce),
    .core_hash(b_core_hash), .tx_busy(b_tx_busy), .send_data(b_send_data),
    .tx_data(b_tx_data), .state_o(b_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [287:0] RES_C1  = {32'h0000_0013, {32{8'hAB}}};
  localparam logic [287:0] RES_C0  = {32'h0000_0055, {32{8'h11}}};
  localparam logic [287:0] RES_NOS = {32'hFFFF_FFFF, 256'h0};

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_job_valid = 1'b0; a_core_done = '0; a_core_found = '0; a_tx_busy = 1'b0;
    a_core_nonce = {32'h0000_0013, 32'h0000_0055};
    a_core_hash  = {{32{8'hAB}}, {32{8'h11}}};
    b_rst = 1'b1; b_job_valid = 1'b0; b_core_done = '0; b_core_found = '0; b_tx_busy = 1'b0;
    b_core_nonce = 32'h1234_5678; b_core_hash = {32{8'h5A}};

    tick(); tick();
    a_rst = 1'b0;
    check("rst_state", a_state, 0);
    check("rst_job_ready", a_job_ready, 1);
    check("rst_core_start", a_core_start, 0);
    check("rst_core_base", a_core_base, 0);
    check("rst_core_abort", a_core_abort, 0);
    check("rst_send_data", a_send_data, 0);
    check("rst_tx_data", a_tx_data, 0);

    a_job_valid = 1'b1; tick(); a_job_valid = 1'b0;
    check("job_ready_low", a_job_ready, 0);
    check("run_state", a_state, 1);
    check("no_start_yet", a_core_start, 0);
    tick();
    check("start0", a_core_start, 2'b01);
    check("base0", a_core_base, 32'h0);
    tick();
    check("start1", a_core_start, 2'b10);
    check("base1", a_core_base, 32'h10);
    tick();
    check("all_busy", a_core_start, 0);
    a_core_done = 2'b01; tick(); a_core_done = '0;
    check("done_no_same_cycle", a_core_start, 0);
    tick();
    check("redispatch_start", a_core_start, 2'b01);
    check("redispatch_base", a_core_base, 32'h20);

    a_job_valid = 1'b1; tick(); a_job_valid = 1'b0;
    check("job_in_run_state", a_state, 1);
    check("job_in_run_start", a_core_start, 0);
    a_core_done = 2'b01; tick();
    check("done_clear", a_core_start, 0);
    tick(); a_core_done = '0;
    check("dispatch_with_idle_done", a_core_start, 2'b01);
    check("dispatch_base30", a_core_base, 32'h30);
    tick();
    check("idle_done_ignored", a_core_start, 0);

    a_core_found = 2'b10; tick(); a_core_found = '0;
    check("found_abort", a_core_abort, 1);
    check("found_state", a_state, 2);
    check("found_no_start", a_core_start, 0);
    tick();
    check("found_send", a_send_data, 1);
    check("found_tx", a_tx_data, RES_C1);
    check("found_idle", a_state, 0);
    check("abort_pulse", a_core_abort, 0);
    tick();
    check("send_pulse", a_send_data, 0);
    check("tx_held", a_tx_data, RES_C1);

    a_job_valid = 1'b1; tick(); a_job_valid = 1'b0;
    a_core_found = 2'b11; tick(); a_core_found = '0;
    check("found_beats_dispatch", a_core_start, 0);
    check("sim_abort", a_core_abort, 1);
    tick();
    check("sim_rr0_send", a_send_data, 1);
    check("sim_rr0_winner", a_tx_data, RES_C0);

    a_job_valid = 1'b1; tick(); a_job_valid = 1'b0;
    tick();
    a_core_found = 2'b11; tick(); a_core_found = '0;
    tick();
    check("sim_rr1_send", a_send_data, 1);
    check("sim_rr1_winner", a_tx_data, RES_C1);

    a_job_valid = 1'b1; tick(); a_job_valid = 1'b0;
    tick();
    a_tx_busy = 1'b1; a_core_found = 2'b01; tick(); a_core_found = '0;
    check("bp_abort", a_core_abort, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {a_send_data, a_state}, {1'b0, 2'd2});
    end
    a_tx_busy = 1'b0; tick();
    check("bp_send", a_send_data, 1);
    check("bp_tx", a_tx_data, RES_C0);

    a_job_valid = 1'b1; tick(); a_job_valid = 1'b0;
    tick();
    check("pre_rst_start", a_core_start, 2'b01);
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    check("mid_rst_state", a_state, 0);
    check("mid_rst_ready", a_job_ready, 1);
    check("mid_rst_start", a_core_start, 0);
    check("mid_rst_abort", a_core_abort, 0);
    check("mid_rst_tx", a_tx_data, 0);

    b_rst = 1'b0;
    b_job_valid = 1'b1; tick(); b_job_valid = 1'b0;
    tick();
    check("ex_start0", b_core_start, 1);
    check("ex_base0", b_core_base, 32'h0);
    b_core_done = 1'b1; tick(); b_core_done = 1'b0;
    check("ex_gap", b_core_start, 0);
    tick();
    check("ex_start1", b_core_start, 1);
    check("ex_base1", b_core_base, 32'h8000_0000);
    tick();
    check("ex_stopped", b_core_start, 0);
    check("ex_running", b_state, 1);
    b_core_done = 1'b1; tick(); b_core_done = 1'b0;
    check("ex_drain", b_state, 1);
    tick();
    check("ex_report", b_state, 2);
    check("ex_tx_load", b_tx_data, RES_NOS);
    tick();
    check("ex_send", b_send_data, 1);
    check("ex_tx", b_tx_data, RES_NOS);
    check("ex_idle", b_state, 0);
    check("ex_no_abort", b_core_abort, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nonce_scheduler.md
Name: nonce_scheduler

Overview:
- Controls the hashing datapath between the UART receiver and transmitter.
- Accepts one mining job and splits the 32-bit nonce space into fixed-size chunks.
- Hands chunks to CORES hashing cores, arbitrates their results and reports one result word to the transmitter.
- Sequences the cores; it does not hash.

Parameters:
- CORES, 1, number of hashing cores driven (1..8).
- CHUNK_LOG, 24, log2 of nonces per chunk (1..31).
- NONCE_W, 32, nonce width (fixed at 32).
- HASH_W, 256, hash width (fixed at 256).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  one-cycle pulse: new job is present on the receiver output.
- job_ready  out  1  high only in IDLE; job_valid is ignored when low.
- core_start  out  CORES  one-hot, one-cycle pulse: core i begins a chunk.
- core_base  out  NONCE_W  first nonce of the chunk; valid only with core_start.
- core_abort  out  1  one-cycle pulse to all cores: stop and go idle.
- core_done  in  CORES  pulse: core i searched its chunk without a hit.
- core_found  in  CORES  pulse: core i found a hit.
- core_nonce  in  CORES*NONCE_W  winning nonce per core; valid with core_found.
- core_hash  in  CORES*HASH_W  winning hash per core; valid with core_found.
- tx_busy  in  1  transmitter is still shifting.
- send_data  out  1  one-cycle pulse: tx_data is valid.
- tx_data  out  288  {nonce[31:0], hash[255:0]}.
- state_o  out  2  current state: 0 IDLE, 1 RUN, 2 REPORT.

Behaviour:
- Reset values: state IDLE; job_ready=1; core_start=0; core_base=0; core_abort=0; send_data=0; tx_data=0; next_base=0; exhausted=0; busy mask=0; rr_ptr=0.
- IDLE:
  - On job_valid: clear next_base, exhausted and busy mask; go to RUN next cycle.
  - job_ready=0 from that cycle on.
- RUN, dispatch:
  - Each cycle with no found event and exhausted=0, the lowest-index non-busy core is dispatched.
  - Dispatch means: core_start[i]=1, core_base=next_base, busy[i] set, next_base += 2^CHUNK_LOG.
  - At most one dispatch per cycle, so a full fill takes CORES cycles.
  - The addition uses NONCE_W+1 bits. A carry-out sets exhausted, and dispatch stops.
- RUN, completion:
  - core_done[i] clears busy[i] in the same cycle.
  - That core becomes dispatchable from the following cycle.
  - core_done on a non-busy core is ignored.
- RUN, found:
  - Any core_found bit (busy or not) is a found event.
  - Winner = first set bit searching upward from rr_ptr, with wrap-around.
  - Latch the winner's nonce and hash into tx_data.
  - Next cycle: pulse core_abort, clear the busy mask, set rr_ptr = winner+1 mod CORES, go to REPORT.
  - A found event takes priority over both dispatch and core_done in the same cycle.
- RUN, exhaustion:
  - When exhausted=1, busy mask=0 and there is no found event, load tx_data = {32'hFFFF_FFFF, 256'h0} and go to REPORT.
  - An all-zero hash marks "no solution".
- REPORT:
  - Wait while tx_busy=1.
  - On the first cycle with tx_busy=0: send_data=1 for exactly one cycle, then go to IDLE.
  - tx_data is held until the next report is loaded.
- rst mid-job: all state returns to reset values on the next edge. core_abort is not pulsed; the cores are reset by the same rst.
- Latency:
  - job_valid to first core_start: 2 cycles.
  - core_found to core_abort: 1 cycle.
  - core_found to send_data, with tx_busy=0: 2 cycles.

Decomposition:
- Shared package miner_pkg holds:
  - NONCE_W, HASH_W, RESULT_W=288.
  - Typedef result_t (packed struct: nonce, hash).
  - NO_SOLUTION constant.
  - Typedef sched_state_e.
- One sub-module: rr_arbiter (parameter N, inputs req and ptr, outputs grant one-hot and grant index). It is purely combinational.
- Everything else stays in nonce_scheduler.

Test Plan (CORES=2, CHUNK_LOG=4 unless stated):
- Basic dispatch: job_valid -> core_start=01 with base 0x0, then core_start=10 with base 0x10 on the next cycle. Then core_done[0] -> core_start=01 with base 0x20.
- Found path: core_found[1] with nonce 0x00000013 and hash 0xAB..AB, tx_busy=0 -> core_abort one cycle later, send_data two cycles later, tx_data={0x00000013, 0xAB..AB}, state returns to IDLE.
- Simultaneous found: core_found=11 with rr_ptr=0 -> core 0 wins. On the next job, core_found=11 -> core 1 wins.
- Exhaustion (CHUNK_LOG=31, CORES=1): bases 0x0 then 0x80000000, then exhausted. The final core_done -> send_data with tx_data={0xFFFFFFFF, 0}.
- Backpressure and busy rules:
  - core_found while tx_busy=1 for 5 cycles -> send_data on the first cycle tx_busy=0.
  - job_valid during RUN is ignored.
  - core_done on an idle core changes nothing.
- Reset mid-run: assert rst for 1 cycle during RUN -> all outputs return to reset values next cycle and job_ready=1.
